bcd_key_accum: RTL and testbench

- Keypad front end that sits directly upstream of the 4-digit BCD adder / seven-segment display path.
- Takes raw push-button levels, synchronises them and detects press edges.
- Shifts pressed decimal digits into a 4-digit BCD entry register.
- On an add press, accumulates the entry into a 4-digit BCD running total with a digit-serial add FSM. Entry and total drive the ssdec display chain.

---
 rtl/bcd_pkg.sv | 6 +
 rtl/bcd_digit_add.sv | 17 +
 rtl/bcd_key_accum.sv | 110 +++++++++++
 tb/tb_bcd_key_accum.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, limit and accumulator FSM states.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  typedef enum logic [1:0] {IDLE, ADD, DONE} accum_state_t;
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD add with carry in/out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co
);
  logic [4:0] t;
  always_comb begin
    t  = 5'(a) + 5'(b) + 5'(ci);
    co = t > 5'(BCD_MAX_DIGIT);
    s  = co ? 4'(t - 5'd10) : t[3:0];
  end
endmodule

// File: rtl/bcd_key_accum.sv
// bcd_key_accum: keypad digit entry with digit-serial BCD accumulation into a running total.
module bcd_key_accum
  import bcd_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [9:0]        digit_keys,
  input  logic              add_key,
  input  logic              clr_key,
  output logic [4*NDIG-1:0] entry,
  output logic [4*NDIG-1:0] total,
  output logic              ovf,
  output logic              busy,
  output logic              done
);
  localparam int W  = 4 * NDIG;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  logic [11:0] sync [SYNC_STAGES];
  logic [11:0] hist, press;
  accum_state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic carry, carry_n, ovf_n, dhit, co;
  logic [W-1:0] shadow, shadow_n, entry_n, total_n;
  bcd_digit_t dsel, sum;
  // Flops reset to 1 so a key held through reset is not seen as a press.
  always_ff @(posedge hz100) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '1;
      hist <= '1;
    end else begin
      sync[0] <= {clr_key, add_key, digit_keys};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      hist <= sync[SYNC_STAGES-1];
    end
  end
  assign press = sync[SYNC_STAGES-1] & ~hist;
  always_comb begin
    dhit = 1'b0;
    dsel = '0;
    for (int i = 9; i >= 0; i--) if (press[i]) begin
      dhit = 1'b1;
      dsel = 4'(i);
    end
  end
  bcd_digit_add u_add (
    .a (entry[idx*4 +: 4]),
    .b (total[idx*4 +: 4]),
    .ci(carry),
    .s (sum),
    .co(co)
  );
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    carry_n  = carry;
    shadow_n = shadow;
    entry_n  = entry;
    total_n  = total;
    ovf_n    = ovf;
    if (press[11]) begin
      state_n = IDLE;
      idx_n   = '0;
      carry_n = 1'b0;
      entry_n = '0;
      total_n = '0;
      ovf_n   = 1'b0;
    end else if (state == IDLE) begin
      if (press[10]) begin
        state_n = ADD;
        idx_n   = '0;
        carry_n = 1'b0;
      end else if (dhit) entry_n = {entry[W-5:0], dsel};
    end else if (state == ADD) begin
      shadow_n[idx*4 +: 4] = sum;
      carry_n = co;
      idx_n   = idx + 1'b1;
      if (idx == IW'(NDIG - 1)) begin
        total_n = shadow_n;
        ovf_n   = ovf | co;
        entry_n = '0;
        idx_n   = '0;
        state_n = DONE;
      end
    end else state_n = IDLE;
  end
  always_ff @(posedge hz100) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      shadow <= '0;
      entry  <= '0;
      total  <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      carry  <= carry_n;
      shadow <= shadow_n;
      entry  <= entry_n;
      total  <= total_n;
      ovf    <= ovf_n;
    end
  end
  assign busy = state == ADD;
  assign done = state == DONE;
endmodule

// File: tb/tb_bcd_key_accum.sv
// tb_bcd_key_accum: vector table, corner sequences and random ops against an arithmetic model.
module tb_bcd_key_accum;
  logic hz100 = 1'b0, reset = 1'b1;
  logic [11:0] kb = '0;
  logic [15:0] entry, total;
  logic ovf, busy, done;
  int n_cmp = 0, n_bad = 0;

  bcd_key_accum dut (
    .hz100(hz100), .reset(reset), .digit_keys(kb[9:0]), .add_key(kb[10]), .clr_key(kb[11]),
    .entry(entry), .total(total), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 hz100 = ~hz100;

  typedef struct {
    logic [11:0] keys;
    logic [15:0] e_entry;
    logic [15:0] e_total;
    logic        e_ovf;
    int          e_done;
  } vec_t;

  vec_t vt[$];

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic op(input logic [11:0] k, output int dn);
    dn = 0;
    kb = k;
    repeat (3) begin tick(); dn += int'(done); end
    kb = '0;
    repeat (8) begin tick(); dn += int'(done); end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    if (!busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy never rose within 20 cycles", name);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] dk(input int d);
    logic [11:0] k = '0;
    k[d] = 1'b1;
    return k;
  endfunction

  initial begin
    int dn, m_entry, m_total, m_ovf, r, d1, d2;
    logic [11:0] k;
    vt.push_back('{dk(1),  16'h0001, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(2),  16'h0012, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(3),  16'h0123, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(4),  16'h1234, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(5),  16'h2345, 16'h0000, 1'b0, 0});
    vt.push_back('{12'h088, 16'h3453, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(11), 16'h0000, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(4),  16'h0004, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(6),  16'h0046, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(7),  16'h0467, 16'h0000, 1'b0, 0});
    vt.push_back('{dk(10), 16'h0000, 16'h0467, 1'b0, 1});
    vt.push_back('{dk(7),  16'h0007, 16'h0467, 1'b0, 0});
    vt.push_back('{dk(5),  16'h0075, 16'h0467, 1'b0, 0});
    vt.push_back('{dk(8),  16'h0758, 16'h0467, 1'b0, 0});
    vt.push_back('{dk(10), 16'h0000, 16'h1225, 1'b0, 1});
    vt.push_back('{dk(11), 16'h0000, 16'h0000, 1'b0, 0});
    for (int i = 0; i < 4; i++) vt.push_back('{dk(9), to_bcd(9999 % (10 ** (i + 1))), 16'h0000, 1'b0, 0});
    vt.push_back('{dk(10), 16'h0000, 16'h9999, 1'b0, 1});
    vt.push_back('{dk(1),  16'h0001, 16'h9999, 1'b0, 0});
    vt.push_back('{dk(10), 16'h0000, 16'h0000, 1'b1, 1});
    vt.push_back('{dk(2),  16'h0002, 16'h0000, 1'b1, 0});
    vt.push_back('{dk(10), 16'h0000, 16'h0002, 1'b1, 1});

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset entry", 32'(entry), 0);
    chk("reset total", 32'(total), 0);
    chk("reset flags", {29'd0, ovf, busy, done}, 0);

    foreach (vt[i]) begin
      op(vt[i].keys, dn);
      chk($sformatf("vec%0d entry", i), 32'(entry), 32'(vt[i].e_entry));
      chk($sformatf("vec%0d total", i), 32'(total), 32'(vt[i].e_total));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vt[i].e_ovf));
      chk($sformatf("vec%0d done count", i), 32'(dn), 32'(vt[i].e_done));
    end

    // presses during busy/done are dropped
    op(dk(11), dn);
    op(dk(5), dn);
    dn = 0;
    kb = dk(10);
    wait_busy("busy ignore");
    kb = dk(6);
    repeat (2) begin tick(); dn += int'(done); end
    kb[10] = 1'b1;
    tick(); dn += int'(done);
    kb[6] = 1'b0;
    tick(); dn += int'(done);
    kb = '0;
    repeat (10) begin tick(); dn += int'(done); end
    chk("busy ignore done count", 32'(dn), 1);
    chk("busy ignore entry", 32'(entry), 0);
    chk("busy ignore total", 32'(total), 32'h0005);

    // clear landing on the second add edge aborts the add
    op(dk(1), dn);
    op(dk(2), dn);
    chk("pre-abort entry", 32'(entry), 32'h0012);
    dn = 0;
    kb = dk(10);
    repeat (2) begin tick(); dn += int'(done); end
    kb[11] = 1'b1;
    repeat (3) begin tick(); dn += int'(done); end
    kb = '0;
    repeat (10) begin tick(); dn += int'(done); end
    chk("abort done count", 32'(dn), 0);
    chk("abort entry", 32'(entry), 0);
    chk("abort total", 32'(total), 0);
    chk("abort busy/ovf", {30'd0, busy, ovf}, 0);

    // key held through reset yields no press
    kb = dk(9);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("held-through-reset entry", 32'(entry), 0);
    kb = '0;
    repeat (4) tick();
    op(dk(9), dn);
    chk("re-press 9 entry", 32'(entry), 32'h0009);

    // reset mid-add
    kb = dk(10);
    wait_busy("reset mid-add");
    chk("mid-add busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    chk("mid-add reset entry", 32'(entry), 0);
    chk("mid-add reset total", 32'(total), 0);
    chk("mid-add reset flags", {29'd0, ovf, busy, done}, 0);
    kb = '0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // random operations against an arithmetic model
    m_entry = 0;
    m_total = 0;
    m_ovf   = 0;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        d1 = int'($urandom_range(0, 9));
        k = dk(d1);
        m_entry = (m_entry * 10 + d1) % 10000;
      end else if (r < 70) begin
        d1 = int'($urandom_range(0, 9));
        d2 = (d1 + int'($urandom_range(1, 9))) % 10;
        k = dk(d1) | dk(d2);
        m_entry = (m_entry * 10 + (d1 < d2 ? d1 : d2)) % 10000;
      end else if (r < 93) begin
        k = dk(10);
        m_total = m_total + m_entry;
        if (m_total > 9999) m_ovf = 1;
        m_total = m_total % 10000;
        m_entry = 0;
      end else begin
        k = dk(11);
        m_entry = 0;
        m_total = 0;
        m_ovf = 0;
      end
      op(k, dn);
      chk($sformatf("rnd%0d entry", n), 32'(entry), 32'(to_bcd(m_entry)));
      chk($sformatf("rnd%0d total", n), 32'(total), 32'(to_bcd(m_total)));
      chk($sformatf("rnd%0d ovf", n), 32'(ovf), 32'(m_ovf));
      chk($sformatf("rnd%0d done count", n), 32'(dn), k[10] ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
